// File: rtl/id_scoreboard_regfile.sv
// id_scoreboard_regfile
//   Decode-stage register file with load-use scoreboard.
//   Holds NREG architectural registers with RD_PORTS combinational read
//   ports (write-through bypass) and one writeback port. Each register
//   has a 4-bit busy counter. A load that issues sets its destination's
//   counter to LOAD_LAT. A valid reader of a busy register raises stall.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   rd_valid              ID instruction requests operand reads
//   rd_use[RD_PORTS]      per-port participation in the hazard check
//   rd_addr / rd_data     packed read addresses / data, port 0 in LSBs
//   wr_en/wr_addr/wr_data writeback port
//   issue_valid/_load/_dst  instruction leaving ID; load flag; destination
//   flush                 kill the instruction in ID
//   stall, hold_pc, hold_if  load-use hazard (all three identical)
//   bubble                stall | flush, zero control fields into EX
//   stall_count           saturating count of stalled cycles
//
// Handshake: the ID instruction issues on a rising edge only when
// issue_valid=1, stall=0 and flush=0 in that cycle. A rejected issue
// leaves the scoreboard untouched apart from the normal decrement.
// rd_addr values must be below NREG.
module id_scoreboard_regfile #(
    parameter int DATA_W   = 32,
    parameter int NREG     = 32,
    parameter int RD_PORTS = 2,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 1,
    parameter int ADDR_W   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_valid,
    input  logic [RD_PORTS-1:0]        rd_use,
    input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
    output logic [RD_PORTS*DATA_W-1:0] rd_data,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       issue_valid,
    input  logic                       issue_load,
    input  logic [ADDR_W-1:0]          issue_dst,
    input  logic                       flush,
    output logic                       stall,
    output logic                       hold_pc,
    output logic                       hold_if,
    output logic                       bubble,
    output logic [15:0]                stall_count
);

    localparam logic [3:0] LAT = 4'(LOAD_LAT);

    logic [DATA_W-1:0]   regs [NREG];
    logic [3:0]          cnt  [NREG];
    logic [NREG-1:0]     busy;
    logic [RD_PORTS-1:0] port_hit;
    logic                issue_accept;
    logic                load_set;

    // Register 0 is hardwired to zero when ZERO_REG is enabled.
    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    always_comb begin
        busy = '0;
        for (int r = 0; r < NREG; r++) begin
            busy[r] = (cnt[r] != 4'd0);
        end
    end

    for (genvar g = 0; g < RD_PORTS; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = rd_addr[g*ADDR_W +: ADDR_W];
        // Same-cycle writeback is forwarded so ID sees the newest value.
        assign rd_data[g*DATA_W +: DATA_W] =
            is_zero(addr)                  ? '0      :
            (wr_en && (wr_addr == addr))   ? wr_data :
                                             regs[addr];
        assign port_hit[g] = rd_use[g] && busy[addr];
    end

    assign stall        = rd_valid && (|port_hit);
    assign hold_pc      = stall;
    assign hold_if      = stall;
    assign bubble       = stall || flush;
    assign issue_accept = issue_valid && !stall && !flush;
    assign load_set     = issue_accept && issue_load && !is_zero(issue_dst);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_en && !is_zero(wr_addr)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Priority per register: new load reload > writeback clear > decrement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= 4'd0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (load_set && (issue_dst == ADDR_W'(r))) begin
                    cnt[r] <= LAT;
                end else if (wr_en && (wr_addr == ADDR_W'(r))) begin
                    cnt[r] <= 4'd0;
                end else if (cnt[r] != 4'd0) begin
                    cnt[r] <= cnt[r] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= 16'd0;
        end else if (stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_scoreboard_regfile.sv
// Testbench for id_scoreboard_regfile. Three instances share one stimulus
// stream: a (LOAD_LAT=1), b (LOAD_LAT=3), c (LOAD_LAT=15, used for the
// long saturation run). The driver pushes a hand-computed expectation each
// cycle; the monitor pops and compares on the falling edge.
module tb_id_scoreboard_regfile;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd_valid;
    logic [1:0]  rd_use;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_valid;
    logic        issue_load;
    logic [4:0]  issue_dst;
    logic        flush;

    logic [63:0] rd_data_a, rd_data_b, rd_data_c;
    logic        stall_a, stall_b, stall_c;
    logic        hold_pc_a, hold_pc_b, hold_pc_c;
    logic        hold_if_a, hold_if_b, hold_if_c;
    logic        bubble_a, bubble_b, bubble_c;
    logic [15:0] sc_a, sc_b, sc_c;

    id_scoreboard_regfile #(.DATA_W(32), .NREG(32), .RD_PORTS(2), .LOAD_LAT(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .rd_valid(rd_valid), .rd_use(rd_use), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_load(issue_load), .issue_dst(issue_dst), .flush(flush),
        .stall(stall_a), .hold_pc(hold_pc_a), .hold_if(hold_if_a), .bubble(bubble_a),
        .stall_count(sc_a));

    id_scoreboard_regfile #(.DATA_W(32), .NREG(32), .RD_PORTS(2), .LOAD_LAT(3), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst(rst), .rd_valid(rd_valid), .rd_use(rd_use), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_load(issue_load), .issue_dst(issue_dst), .flush(flush),
        .stall(stall_b), .hold_pc(hold_pc_b), .hold_if(hold_if_b), .bubble(bubble_b),
        .stall_count(sc_b));

    id_scoreboard_regfile #(.DATA_W(32), .NREG(32), .RD_PORTS(2), .LOAD_LAT(15), .ZERO_REG(1)) dut_c (
        .clk(clk), .rst(rst), .rd_valid(rd_valid), .rd_use(rd_use), .rd_addr(rd_addr),
        .rd_data(rd_data_c), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_load(issue_load), .issue_dst(issue_dst), .flush(flush),
        .stall(stall_c), .hold_pc(hold_pc_c), .hold_if(hold_if_c), .bubble(bubble_c),
        .stall_count(sc_c));

    // chk/st/bu bit i refers to instance a (0), b (1), c (2); sc = {c, b, a}.
    typedef struct {
        string       name;
        bit          crd;
        logic [31:0] r0;
        logic [31:0] r1;
        logic [2:0]  chk;
        logic [2:0]  st;
        logic [2:0]  bu;
        logic [47:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin : mon
            exp_t        e;
            logic [2:0]  act_st, act_hp, act_hi, act_bu;
            logic [47:0] act_sc;
            e      = exp_q.pop_front();
            act_st = {stall_c, stall_b, stall_a};
            act_hp = {hold_pc_c, hold_pc_b, hold_pc_a};
            act_hi = {hold_if_c, hold_if_b, hold_if_a};
            act_bu = {bubble_c, bubble_b, bubble_a};
            act_sc = {sc_c, sc_b, sc_a};
            if (e.crd) begin
                cmp($sformatf("%s.rd0", e.name), 64'(rd_data_a[31:0]), 64'(e.r0));
                cmp($sformatf("%s.rd1", e.name), 64'(rd_data_a[63:32]), 64'(e.r1));
            end
            for (int i = 0; i < 3; i++) begin
                if (e.chk[i]) begin
                    cmp($sformatf("%s.stall%0d", e.name, i), 64'(act_st[i]), 64'(e.st[i]));
                    cmp($sformatf("%s.hold_pc%0d", e.name, i), 64'(act_hp[i]), 64'(e.st[i]));
                    cmp($sformatf("%s.hold_if%0d", e.name, i), 64'(act_hi[i]), 64'(e.st[i]));
                    cmp($sformatf("%s.bubble%0d", e.name, i), 64'(act_bu[i]), 64'(e.bu[i]));
                    cmp($sformatf("%s.stall_count%0d", e.name, i),
                        64'(act_sc[16*i +: 16]), 64'(e.sc[16*i +: 16]));
                end
            end
        end
    end

    // Driver tasks
    task automatic set_in(input logic rv, input logic [1:0] use_m, input logic [4:0] a0,
                          input logic [4:0] a1, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd, input logic iv, input logic il,
                          input logic [4:0] id, input logic fl);
        rd_valid    = rv;
        rd_use      = use_m;
        rd_addr     = {a1, a0};
        wr_en       = we;
        wr_addr     = wa;
        wr_data     = wd;
        issue_valid = iv;
        issue_load  = il;
        issue_dst   = id;
        flush       = fl;
    endtask

    task automatic push(input string n, input bit crd, input logic [31:0] r0, input logic [31:0] r1,
                        input logic [2:0] chk, input logic [2:0] st, input logic [2:0] bu,
                        input logic [15:0] sa, input logic [15:0] sb, input logic [15:0] scc);
        exp_t e;
        e.name = n; e.crd = crd; e.r0 = r0; e.r1 = r1;
        e.chk = chk; e.st = st; e.bu = bu; e.sc = {scc, sb, sa};
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] dst);
        set_in(0, 2'b00, 0, 0, 0, 0, 0, 1, 1, dst, 0);
    endtask

    initial begin
        rst = 1'b0;
        set_in(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Reset: writes ignored but bypassed, bubble follows flush
        set_in(0, 2'b00, 5, 6, 1, 5, 32'hDEADBEEF, 0, 0, 0, 1);
        push("rst_hold", 1, 32'hDEADBEEF, 32'h0, 3'b111, 3'b000, 3'b111, 0, 0, 0); tick();
        rst = 1'b1;
        set_in(0, 2'b00, 5, 6, 0, 0, 0, 0, 0, 0, 0);
        push("rst_wr_ignored", 1, 32'h0, 32'h0, 3'b011, 3'b000, 3'b000, 0, 0, 0); tick();

        // Register file reads, bypass, zero register
        set_in(0, 2'b00, 0, 0, 1, 5, 32'h12345678, 0, 0, 0, 0);
        push("wr_r5", 1, 32'h0, 32'h0, 3'b011, 3'b000, 3'b000, 0, 0, 0); tick();
        set_in(0, 2'b00, 5, 5, 0, 0, 0, 0, 0, 0, 0);
        push("rd_r5_dup", 1, 32'h12345678, 32'h12345678, 3'b011, 3'b000, 3'b000, 0, 0, 0); tick();
        set_in(0, 2'b00, 6, 5, 1, 6, 32'hA5A5A5A5, 0, 0, 0, 0);
        push("bypass_r6", 1, 32'hA5A5A5A5, 32'h12345678, 3'b011, 3'b000, 3'b000, 0, 0, 0); tick();
        set_in(0, 2'b00, 0, 6, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
        push("wr_r0_nobypass", 1, 32'h0, 32'hA5A5A5A5, 3'b011, 3'b000, 3'b000, 0, 0, 0); tick();
        set_in(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push("rd_r0", 1, 32'h0, 32'h0, 3'b011, 3'b000, 3'b000, 0, 0, 0); tick();
        load(0);
        push("load_r0", 0, 0, 0, 3'b011, 3'b000, 3'b000, 0, 0, 0); tick();
        set_in(1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push("use_r0", 1, 32'h0, 32'h0, 3'b011, 3'b000, 3'b000, 0, 0, 0); tick();

        // Load r3 then consumer on port 0
        load(3);
        push("load_r3", 0, 0, 0, 3'b011, 3'b000, 3'b000, 0, 0, 0); tick();
        set_in(1, 2'b01, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        push("r3_use_c1", 0, 0, 0, 3'b011, 3'b011, 3'b011, 0, 0, 0); tick();
        push("r3_use_c2", 0, 0, 0, 3'b011, 3'b010, 3'b010, 1, 1, 0); tick();
        push("r3_use_c3", 0, 0, 0, 3'b011, 3'b010, 3'b010, 1, 2, 0); tick();
        push("r3_use_c4", 0, 0, 0, 3'b011, 3'b000, 3'b000, 1, 3, 0); tick();

        // Load r7, consumer on port 1 only
        load(7);
        push("load_r7", 0, 0, 0, 3'b011, 3'b000, 3'b000, 1, 3, 0); tick();
        set_in(1, 2'b10, 0, 7, 0, 0, 0, 0, 0, 0, 0);
        push("r7_p1_c1", 0, 0, 0, 3'b011, 3'b011, 3'b011, 1, 3, 0); tick();
        push("r7_p1_c2", 0, 0, 0, 3'b011, 3'b010, 3'b010, 2, 4, 0); tick();
        push("r7_p1_c3", 0, 0, 0, 3'b011, 3'b010, 3'b010, 2, 5, 0); tick();

        // Masked port, then writeback clears busy early
        load(7);
        push("reload_r7", 0, 0, 0, 3'b011, 3'b000, 3'b000, 2, 6, 0); tick();
        set_in(1, 2'b01, 0, 7, 0, 0, 0, 0, 0, 0, 0);
        push("mask_port1", 0, 0, 0, 3'b011, 3'b000, 3'b000, 2, 6, 0); tick();
        set_in(1, 2'b10, 7, 7, 1, 7, 32'h00000077, 0, 0, 0, 0);
        push("wr_r7", 1, 32'h77, 32'h77, 3'b011, 3'b010, 3'b010, 2, 6, 0); tick();
        set_in(1, 2'b10, 7, 7, 0, 0, 0, 0, 0, 0, 0);
        push("early_release", 1, 32'h77, 32'h77, 3'b011, 3'b000, 3'b000, 2, 7, 0); tick();

        // Flush during stall rejects a reload of the busy register
        load(9);
        push("load_r9", 0, 0, 0, 3'b011, 3'b000, 3'b000, 2, 7, 0); tick();
        set_in(1, 2'b01, 9, 0, 0, 0, 0, 1, 1, 9, 1);
        push("flush_in_stall", 0, 0, 0, 3'b011, 3'b011, 3'b011, 2, 7, 0); tick();
        set_in(1, 2'b01, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        push("flush_rej_c1", 0, 0, 0, 3'b011, 3'b010, 3'b010, 3, 8, 0); tick();
        push("flush_rej_c2", 0, 0, 0, 3'b011, 3'b010, 3'b010, 3, 9, 0); tick();
        push("flush_rej_c3", 0, 0, 0, 3'b011, 3'b000, 3'b000, 3, 10, 0); tick();
        set_in(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        push("flush_only", 0, 0, 0, 3'b011, 3'b000, 3'b011, 3, 10, 0); tick();

        // Reload of a busy register restarts its count
        load(10);
        push("load_r10", 0, 0, 0, 3'b011, 3'b000, 3'b000, 3, 10, 0); tick();
        push("reload_r10", 0, 0, 0, 3'b011, 3'b000, 3'b000, 3, 10, 0); tick();
        set_in(1, 2'b01, 10, 0, 0, 0, 0, 0, 0, 0, 0);
        push("r10_c1", 0, 0, 0, 3'b011, 3'b011, 3'b011, 3, 10, 0); tick();
        push("r10_c2", 0, 0, 0, 3'b011, 3'b010, 3'b010, 4, 11, 0); tick();
        push("r10_c3", 0, 0, 0, 3'b011, 3'b010, 3'b010, 4, 12, 0); tick();
        push("r10_c4", 0, 0, 0, 3'b011, 3'b000, 3'b000, 4, 13, 0); tick();

        // Reload wins over a same-cycle writeback to the same register
        set_in(0, 2'b00, 11, 0, 1, 11, 32'h000000BB, 1, 1, 11, 0);
        push("load_wr_r11", 1, 32'hBB, 32'h0, 3'b011, 3'b000, 3'b000, 4, 13, 0); tick();
        set_in(1, 2'b01, 11, 0, 0, 0, 0, 0, 0, 0, 0);
        push("reload_won", 1, 32'hBB, 32'h0, 3'b011, 3'b011, 3'b011, 4, 13, 0); tick();
        set_in(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push("after_r11", 0, 0, 0, 3'b011, 3'b000, 3'b000, 5, 14, 0); tick();

        // Saturation run on instance c: 15 stalled cycles per 16
        for (int p = 0; p < 4400; p++) begin
            load(12);
            tick();
            set_in(1, 2'b01, 12, 0, 0, 0, 0, 0, 0, 0, 0);
            for (int k = 0; k < 15; k++) tick();
        end
        load(12);
        push("sat_idle", 0, 0, 0, 3'b100, 3'b000, 3'b000, 0, 0, 16'hFFFF); tick();
        set_in(1, 2'b01, 12, 5, 0, 0, 0, 0, 0, 0, 0);
        push("sat_stall", 0, 0, 0, 3'b100, 3'b100, 3'b100, 0, 0, 16'hFFFF); tick();
        push("sat_hold", 0, 0, 0, 3'b100, 3'b100, 3'b100, 0, 0, 16'hFFFF); tick();

        // Asynchronous reset in the middle of a stall
        rst = 1'b0;
        push("async_rst", 1, 32'h0, 32'h0, 3'b111, 3'b000, 3'b000, 0, 0, 0); tick();
        rst = 1'b1;
        set_in(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL exp_q_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_scoreboard_regfile.md
ID_SCOREBOARD_REGFILE -- requirements
Module: id_scoreboard_regfile

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter NREG, default 32, number of architectural registers; ADDR_W = clog2(NREG).
REQ-003 Parameter RD_PORTS, default 2, number of combinational read ports.
REQ-004 Parameter LOAD_LAT, default 1, range 1..15; cycles a load destination stays busy after issue.
REQ-005 Parameter ZERO_REG, default 1; when 1, register 0 reads 0, ignores writes, and is never busy.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 rd_valid  in  1  instruction in ID is valid and requests operand reads.
REQ-009 rd_use  in  RD_PORTS  per-port mask; port i participates in hazard check only if bit i set.
REQ-010 rd_addr  in  RD_PORTS*ADDR_W  packed read addresses, port 0 in LSBs.
REQ-011 rd_data  out  RD_PORTS*DATA_W  packed read data, port 0 in LSBs.
REQ-012 wr_en / wr_addr / wr_data  in  1 / ADDR_W / DATA_W  writeback port.
REQ-013 issue_valid  in  1  instruction in ID leaves to EX this cycle if not stalled.
REQ-014 issue_load  in  1  issuing instruction is a load.
REQ-015 issue_dst  in  ADDR_W  destination register of issuing instruction.
REQ-016 flush  in  1  kill the instruction in ID.
REQ-017 stall  out  1  load-use hazard detected.
REQ-018 hold_pc / hold_if  out  1 / 1  freeze PC and IF/ID register; both equal stall.
REQ-019 bubble  out  1  zero control fields into EX; equals stall OR flush.
REQ-020 stall_count  out  16  saturating count of stalled cycles since reset.

Function
REQ-021 Register write occurs on rising clk when wr_en=1, except wr_addr=0 with ZERO_REG=1.
REQ-022 rd_data port i is combinational: wr_data if wr_en=1 and wr_addr=rd_addr[i] (write-through bypass, not for reg 0 when ZERO_REG=1), else stored value.
REQ-023 Read of register 0 with ZERO_REG=1 returns 0 regardless of any write.
REQ-024 Each register has a 4-bit busy counter cnt[r]; busy[r] = (cnt[r] != 0).
REQ-025 stall = rd_valid AND any i with rd_use[i]=1 AND busy[rd_addr[i]]=1; combinational, same cycle.
REQ-026 Issue is accepted iff issue_valid=1, stall=0, flush=0.
REQ-027 Accepted issue with issue_load=1 loads cnt[issue_dst] <= LOAD_LAT (skipped for reg 0 when ZERO_REG=1).
REQ-028 Every other nonzero cnt[r] decrements by 1 per cycle; counters never wrap below 0.
REQ-029 wr_en=1 to register r clears cnt[r] next edge (data arrived), unless REQ-027 reloads r the same cycle; reload wins.
REQ-030 Reload of an already busy register restarts its count at LOAD_LAT.
REQ-031 With LOAD_LAT=1, a load followed immediately by a consumer produces exactly one stall cycle.
REQ-032 flush=1 with stall=1: bubble=1, issue rejected, scoreboard only decrements.
REQ-033 stall_count increments each cycle stall=1; holds at 16'hFFFF.
REQ-034 Duplicate rd_addr across ports is legal; each port returns identical data.

Reset
REQ-035 rst=0 asynchronously clears all registers to 0, all cnt to 0, stall_count to 0.
REQ-036 During reset stall, hold_pc, hold_if = 0; bubble follows flush; rd_data returns 0 unless bypassed write — writes ignored while rst=0.
REQ-037 Reset asserted mid-stall releases stall in the same cycle (async).

Verification
REQ-038 Write r5=0x1234_5678, next cycle read port0 r5 -> rd_data[0]=0x12345678; same-cycle write/read r6=0xA5A5A5A5 -> bypassed value.
REQ-039 Write r0=0xFFFFFFFF, ZERO_REG=1 -> r0 reads 0; issue load to r0 then consumer of r0 -> stall=0.
REQ-040 LOAD_LAT=1: issue load r3, next cycle rd_valid, rd_use=01, rd_addr0=3 -> stall=1 one cycle, hold_pc=hold_if=bubble=1, stall_count=1; following cycle stall=0.
REQ-041 LOAD_LAT=3: load r7, consumer of r7 on port1 only, rd_use=10 -> stall 3 cycles; same with rd_use=01 and r7 on port1 -> stall=0.
REQ-042 LOAD_LAT=3: load r7, wr_en r7 one cycle later -> busy cleared, stall ends early; flush during stall -> issue rejected, bubble=1.
REQ-043 Force 65540 stalled cycles -> stall_count=0xFFFF; assert rst=0 mid-stall -> stall=0 immediately, stall_count=0.
